mem_burst_ctrl: RTL and testbench
=================================

// Module: mem_burst_ctrl
// PURPOSE
// - Main-memory-side controller directly downstream of the 2-way cache controller.
// - Serves whole-block (4-byte) reads and writes over a byte-serial link using the cache's rd_mem/wr_mem/ready_mem handshake.
// - Applies a programmable access latency.
// - Holds the backing store in one block-wide synchronous RAM.
// PARAMETERS
// - AWIDTH     9  byte address width; block address = addr_mem[AWIDTH-1:2]
// - DWIDTH     8  byte lane width
// - BLOCKSIZE  4  bytes per block; fixed at 4 for this revision
// - LATENCY    2  wait cycles between request acceptance and read data (read) or last byte and commit (write); legal range 1..15
// PORTS
// - clock        in   1               system clock, same as the cache
// - reset_n      in   1               asynchronous, active-low reset
// - addr_mem     in   AWIDTH          request address; bits [1:0] ignored
// - rd_mem       in   1               block read request
// - wr_mem       in   1               block write request
// - wdata_mem    in   DWIDTH          write byte stream from the cache
// - rdata_mem    out  DWIDTH          read byte stream to the cache
// - rdata_oe     out  1               drive enable for the top-level tri-state data_mem bus; equals rvalid_mem
// - rvalid_mem   out  1               rdata_mem carries a valid byte this cycle
// - ready_mem    out  1               controller idle and able to accept a request
// BEHAVIOUR
// - Reset values: ready_mem=1, rvalid_mem=0, rdata_oe=0, rdata_mem=0, state=IDLE, counters=0.
// - RAM contents are not cleared by reset.
// - Reset at any point aborts the current transfer; no partial block is ever written.
// - States: IDLE, RLAT, RBURST, WBURST, WLAT.
// - Acceptance: a request is accepted at edge T when ready_mem=1 and (rd_mem|wr_mem) is sampled high.
//   - Block address latched at T.
//   - ready_mem goes 0 after T.
// - rd_mem and wr_mem both high at acceptance: the write wins; the read is dropped.
// - Requests while ready_mem=0 are ignored; no queueing.
// - Read path:
//   - IDLE -> RLAT at T.
//   - RLAT counts LATENCY cycles; RAM read issued in RLAT.
//   - RLAT -> RBURST.
//   - RBURST asserts rvalid_mem for exactly 4 consecutive cycles, bytes in order [7:0], [15:8], [23:16], [31:24].
//   - First valid byte is seen in cycle T+LATENCY+1.
//   - After the 4th byte: -> IDLE; ready_mem=1 in the next cycle.
// - Write path:
//   - IDLE -> WBURST at T.
//   - wdata_mem sampled on edges T+1..T+4 and shifted into a 32-bit assembly register, byte 0 first (low lane).
//   - WBURST -> WLAT; WLAT counts LATENCY cycles.
//   - Full 32-bit block written to the RAM on the last WLAT edge; -> IDLE with ready_mem=1.
// - Burst and latency counters are 4 bits and saturate-free: they reload on every acceptance, so there is no wrap-around hazard.
// - A write immediately followed by a read of the same block returns the new data; the commit precedes ready_mem rising.
// - rdata_mem holds its last value when rvalid_mem=0; only rdata_oe gates bus drive.
// STRUCTURE
// - Package mem_ctrl_pkg:
//   - mem_state_t enum {IDLE, RLAT, RBURST, WBURST, WLAT}
//   - localparams BLOCKSIZE=4 and BLKW=DWIDTH*BLOCKSIZE
// - Sub-module mem_block_ram:
//   - 2^(AWIDTH-2) x BLKW
//   - synchronous write (we, addr, din)
//   - registered read (re, addr, dout)
// - The controller owns the FSM, counters, byte assembly and byte-select mux.
// TESTING
// - Reset then idle: ready_mem=1, rvalid_mem=0, rdata_oe=0 for 10 cycles with no requests.
// - Write then read back:
//   - wr_mem at addr 9'h0A4 with bytes 11,22,33,44, then rd_mem at addr 9'h0A7.
//   - Read returns 11,22,33,44 on 4 consecutive rvalid_mem cycles starting T+3 (LATENCY=2).
// - Simultaneous rd_mem=1 and wr_mem=1 at addr 9'h010 with bytes AA,BB,CC,DD:
//   - Write performed; no rvalid_mem pulses.
//   - A later read of 9'h010 returns AA,BB,CC,DD.
// - Request while busy:
//   - rd_mem pulsed during WBURST at a different address is ignored.
//   - Exactly one transaction completes; ready_mem stays 0 until WLAT ends.
// - Reset mid-write: reset_n low after byte 2 of a write to 9'h020 holding 01,02,03,04.
//   - A subsequent read of 9'h020 returns 01,02,03,04 unchanged.
// - LATENCY=5 build: first rvalid_mem at T+6; ready_mem low for exactly 9 cycles on a read.

Source files
------------

// File: rtl/mem_burst_ctrl_pkg.sv
// rtl/mem_burst_ctrl_pkg.sv - shared types and constants for the memory burst controller
//
// Purpose: controller state encoding and block geometry constants.
// Ports  : none (package).
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RLAT,
      RBURST,
      WBURST,
      WLAT
   } mem_state_t;

   localparam int BYTE_W    = 8;
   localparam int BLOCKSIZE = 4;
   localparam int BLKW      = BYTE_W * BLOCKSIZE;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// rtl/mem_burst_ctrl_if.sv - cache-to-memory byte-serial block bus
//
// Purpose: groups the rd_mem/wr_mem/ready_mem handshake and byte streams.
// Ports  : addr_mem, rd_mem, wr_mem, wdata_mem   (cache -> memory)
//          rdata_mem, rdata_oe, rvalid_mem, ready_mem (memory -> cache)
// Modports: master = cache side, slave = memory controller side.
interface mem_burst_ctrl_if #(
   parameter int AWIDTH = 9,
   parameter int DWIDTH = 8
);
   logic [AWIDTH-1:0] addr_mem;
   logic              rd_mem;
   logic              wr_mem;
   logic [DWIDTH-1:0] wdata_mem;
   logic [DWIDTH-1:0] rdata_mem;
   logic              rdata_oe;
   logic              rvalid_mem;
   logic              ready_mem;

   modport master (
      output addr_mem, rd_mem, wr_mem, wdata_mem,
      input  rdata_mem, rdata_oe, rvalid_mem, ready_mem
   );

   modport slave (
      input  addr_mem, rd_mem, wr_mem, wdata_mem,
      output rdata_mem, rdata_oe, rvalid_mem, ready_mem
   );
endinterface

// File: rtl/mem_burst_ctrl_ram.sv
// rtl/mem_burst_ctrl_ram.sv - block-wide backing store with registered read
//
// Purpose: 2^AW x W synchronous RAM; contents are never reset.
// Ports  : clock; we/addr/din synchronous write; re/addr/dout registered read.
module mem_block_ram #(
   parameter int AW = 7,
   parameter int W  = 32
) (
   input  logic          clock,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout
);
   logic [W-1:0] mem [2**AW];

   always_ff @(posedge clock) begin
      if (we)
         mem[addr] <= din;
      if (re)
         dout <= mem[addr];
   end
endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - main-memory block controller behind the cache
//
// Purpose: serves whole-block reads and writes over a byte-serial link with a
//          programmable access latency (LATENCY, 1..15).
// Ports  : clock, reset_n (async, active-low)
//          bus : mem_burst_ctrl_if.slave (request, byte streams, ready/valid)
module mem_burst_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int AWIDTH  = 9,
   parameter int DWIDTH  = 8,
   parameter int LATENCY = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   mem_burst_ctrl_if.slave    bus
);
   localparam int BW  = DWIDTH * BLOCKSIZE;
   localparam int BAW = AWIDTH - 2;
   localparam logic [3:0] LAST_LAT  = 4'(LATENCY - 1);
   localparam logic [3:0] LAST_BYTE = 4'(BLOCKSIZE - 1);

   mem_state_t        state;
   logic [3:0]        cnt;
   logic [BAW-1:0]    blk_addr;
   logic [BW-1:0]     asm_q;
   logic              ready_q;
   logic              rvalid_q;
   logic [DWIDTH-1:0] rdata_q;

   logic              accept;
   logic              ram_we;
   logic              ram_re;
   logic [BAW-1:0]    ram_addr;
   logic [BW-1:0]     ram_dout;
   logic [1:0]        nxt_sel;
   logic [DWIDTH-1:0] nxt_byte;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^bus.addr_mem[1:0];

   assign accept = ready_q & (bus.rd_mem | bus.wr_mem);

   // The block read is launched on the accepting edge so the RAM output is
   // stable throughout RLAT, which lets LATENCY=1 still present byte 0 on
   // the RLAT exit edge.
   assign ram_re   = accept & ~bus.wr_mem;
   assign ram_we   = (state == WLAT) && (cnt == LAST_LAT);
   assign ram_addr = accept ? bus.addr_mem[AWIDTH-1:2] : blk_addr;

   assign nxt_sel  = cnt[1:0] + 2'd1;
   assign nxt_byte = ram_dout[DWIDTH*nxt_sel +: DWIDTH];

   mem_block_ram #(.AW(BAW), .W(BW)) u_ram (
      .clock (clock),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .din   (asm_q),
      .dout  (ram_dout)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         blk_addr <= '0;
         asm_q    <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.rd_mem | bus.wr_mem) begin
                  blk_addr <= bus.addr_mem[AWIDTH-1:2];
                  cnt      <= '0;
                  ready_q  <= 1'b0;
                  // Write wins when both are asserted.
                  state    <= bus.wr_mem ? WBURST : RLAT;
               end
            end
            RLAT: begin
               if (cnt == LAST_LAT) begin
                  cnt      <= '0;
                  rvalid_q <= 1'b1;
                  rdata_q  <= ram_dout[DWIDTH-1:0];
                  state    <= RBURST;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RBURST: begin
               if (cnt == LAST_BYTE) begin
                  cnt      <= '0;
                  rvalid_q <= 1'b0;
                  ready_q  <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt     <= cnt + 4'd1;
                  rdata_q <= nxt_byte;
               end
            end
            WBURST: begin
               // Shift right so the first byte ends up in the low lane.
               asm_q <= {bus.wdata_mem, asm_q[BW-1:DWIDTH]};
               if (cnt == LAST_BYTE) begin
                  cnt   <= '0;
                  state <= WLAT;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            WLAT: begin
               // RAM commit happens on this same edge via ram_we.
               if (cnt == LAST_LAT) begin
                  cnt     <= '0;
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready_mem  = ready_q;
   assign bus.rvalid_mem = rvalid_q;
   assign bus.rdata_oe   = rvalid_q;
   assign bus.rdata_mem  = rdata_q;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - directed self-checking bench for mem_burst_ctrl
module tb_mem_burst_ctrl;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       sel = 1'b0;
   logic       rd = 1'b0;
   logic       wr = 1'b0;
   logic [8:0] addr = '0;
   logic [7:0] wdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_burst_ctrl_if #(.AWIDTH(9), .DWIDTH(8)) bus2 ();
   mem_burst_ctrl_if #(.AWIDTH(9), .DWIDTH(8)) bus5 ();

   assign bus2.addr_mem  = addr;
   assign bus2.rd_mem    = rd & ~sel;
   assign bus2.wr_mem    = wr & ~sel;
   assign bus2.wdata_mem = wdata;
   assign bus5.addr_mem  = addr;
   assign bus5.rd_mem    = rd & sel;
   assign bus5.wr_mem    = wr & sel;
   assign bus5.wdata_mem = wdata;

   wire       obs_ready  = sel ? bus5.ready_mem  : bus2.ready_mem;
   wire       obs_rvalid = sel ? bus5.rvalid_mem : bus2.rvalid_mem;
   wire       obs_oe     = sel ? bus5.rdata_oe   : bus2.rdata_oe;
   wire [7:0] obs_rdata  = sel ? bus5.rdata_mem  : bus2.rdata_mem;

   mem_burst_ctrl #(.AWIDTH(9), .DWIDTH(8), .LATENCY(2)) dut2 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus2)
   );

   mem_burst_ctrl #(.AWIDTH(9), .DWIDTH(8), .LATENCY(5)) dut5 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (obs_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_ready_wait"}, {31'd0, obs_ready}, 32'd1);
   endtask

   // Write one block; optionally with rd_mem also high at acceptance, and
   // optionally a stray read request pulsed during the byte burst.
   task automatic do_write(input string tag, input logic [8:0] a, input logic [31:0] blk,
                           input bit also_rd, input bit busy_rd, input int lat);
      int k = 0;
      int low = 0;
      int pulses = 0;
      wait_ready(tag);
      addr = a;
      wr = 1'b1;
      rd = also_rd;
      tick();
      wr = 1'b0;
      rd = 1'b0;
      while (k < 40) begin
         if (obs_ready === 1'b1) break;
         low++;
         if (obs_rvalid === 1'b1) pulses++;
         if (k < 4) wdata = blk[8*k +: 8];
         rd = busy_rd && (k == 1);
         addr = (busy_rd && k == 1) ? (a ^ 9'h080) : a;
         tick();
         k++;
      end
      rd = 1'b0;
      check({tag, "_wr_ready_low"}, low, 4 + lat);
      check({tag, "_wr_no_rvalid"}, pulses, 0);
   endtask

   task automatic do_read(input string tag, input logic [8:0] a, input logic [31:0] exp, input int lat);
      int k = 0;
      int first = -1;
      int n = 0;
      int low = 0;
      int oe_bad = 0;
      logic [31:0] got = '0;
      wait_ready(tag);
      addr = a;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      while (k < 40) begin
         if (obs_ready === 1'b1) break;
         low++;
         if (obs_oe !== obs_rvalid) oe_bad++;
         if (obs_rvalid === 1'b1) begin
            if (first < 0) first = k;
            if (n < 4) got[8*n +: 8] = obs_rdata;
            n++;
         end
         tick();
         k++;
      end
      check({tag, "_rd_first_valid"}, first, lat);
      check({tag, "_rd_pulses"}, n, 4);
      check({tag, "_rd_data"}, got, exp);
      check({tag, "_rd_ready_low"}, low, lat + 4);
      check({tag, "_rd_oe_eq_rvalid"}, oe_bad, 0);
      check({tag, "_rd_hold"}, {24'd0, obs_rdata}, {24'd0, exp[31:24]});
      check({tag, "_rd_idle_rvalid"}, {31'd0, obs_rvalid}, 32'd0);
   endtask

   initial begin
      // Reset and idle
      repeat (3) tick();
      check("rst_ready",  {31'd0, obs_ready},  32'd1);
      check("rst_rvalid", {31'd0, obs_rvalid}, 32'd0);
      check("rst_oe",     {31'd0, obs_oe},     32'd0);
      check("rst_rdata",  {24'd0, obs_rdata},  32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_ready",  {31'd0, obs_ready},  32'd1);
         check("idle_rvalid", {31'd0, obs_rvalid}, 32'd0);
         check("idle_oe",     {31'd0, obs_oe},     32'd0);
      end

      // Write then read back through ignored low address bits
      do_write("wr_a4", 9'h0A4, 32'h44332211, 1'b0, 1'b0, 2);
      do_read("rd_a7", 9'h0A7, 32'h44332211, 2);

      // Simultaneous read and write: write wins
      do_write("both_10", 9'h010, 32'hDDCCBBAA, 1'b1, 1'b0, 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("both_no_rvalid", {31'd0, obs_rvalid}, 32'd0);
      end
      do_read("rd_10", 9'h010, 32'hDDCCBBAA, 2);

      // Request while busy is ignored
      do_write("busy_30", 9'h030, 32'h8877665A, 1'b0, 1'b1, 2);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("busy_no_rvalid", {31'd0, obs_rvalid}, 32'd0);
         check("busy_ready",     {31'd0, obs_ready},  32'd1);
      end
      do_read("rd_30", 9'h030, 32'h8877665A, 2);

      // Reset mid-write leaves the old block intact
      do_write("pre_20", 9'h020, 32'h04030201, 1'b0, 1'b0, 2);
      wait_ready("abort");
      addr = 9'h020;
      wr = 1'b1;
      tick();
      wr = 1'b0;
      wdata = 8'hF1;
      tick();
      wdata = 8'hF2;
      tick();
      check("abort_busy", {31'd0, obs_ready}, 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check("abort_ready_async", {31'd0, obs_ready},  32'd1);
      check("abort_rvalid",      {31'd0, obs_rvalid}, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      do_read("rd_20", 9'h020, 32'h04030201, 2);

      // LATENCY=5 instance
      sel = 1'b1;
      tick();
      do_write("l5_wr", 9'h040, 32'h08070605, 1'b0, 1'b0, 5);
      do_read("l5_rd", 9'h040, 32'h08070605, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
